// File: rtl/warp_fetch_unit_pkg.sv
// Shared types for the warp fetch stage: warp-id sizing, FSM encoding and
// the buffered fetch entry {warp, pc, instr}.
package warp_fetch_unit_pkg;

    localparam int WARP_ID_W = 2;
    localparam int NUM_WARPS = 1 << WARP_ID_W;
    localparam int PC_W      = 5;
    localparam int INSTR_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WARP_ID_W-1:0] warp;
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
    } fetch_entry_t;

    function automatic logic warp_match(input logic [WARP_ID_W-1:0] a,
                                        input logic [WARP_ID_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/warp_fetch_unit_fetch_buffer.sv
// Small circular FIFO of fetch entries with a kill bit per slot; killed
// entries stay in order and are dropped by the consumer when they reach the head.
module fetch_buffer
    import warp_fetch_unit_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  fetch_entry_t         push_entry,
    input  logic                 pop,
    input  logic                 kill,
    input  logic [WARP_ID_W-1:0] kill_warp,
    output fetch_entry_t         head,
    output logic                 head_killed,
    output logic [AW:0]          count,
    output logic                 empty
);

    fetch_entry_t          mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill_bits;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic                  full;

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign head        = mem[rd_ptr];
    assign head_killed = kill_bits[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            kill_bits <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Stale kill bits on free slots are harmless: a push clears its slot's bit.
            if (kill) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (warp_match(mem[i].warp, kill_warp)) begin
                        kill_bits[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                mem[wr_ptr]       <= push_entry;
                kill_bits[wr_ptr] <= 1'b0;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/warp_fetch_unit.sv
// Instruction-fetch stage: takes {warp, pc} from the scheduler, runs one
// outstanding imem read at a time and queues results for decode, with per-warp flush.
module warp_fetch_unit
    import warp_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = PC_W,
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int WARP_W      = WARP_ID_W,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [WARP_W-1:0]      sched_warp,
    input  logic [PC_WIDTH-1:0]    sched_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   flush,
    input  logic [WARP_W-1:0]      flush_warp,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [WARP_W-1:0]      dec_warp,
    output logic [PC_WIDTH-1:0]    dec_pc,
    output logic [INSTR_WIDTH-1:0] dec_instr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [WARP_W-1:0]   req_warp;
    logic [PC_WIDTH-1:0] req_pc;
    logic                drop;

    logic                accept;
    logic                push;
    logic                pop;
    logic                flush_hit_req;
    logic                flush_hit_sched;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;
    logic                head_killed;
    logic                empty;
    logic [AW:0]         count;

    assign flush_hit_req   = flush && warp_match(flush_warp, req_warp);
    assign flush_hit_sched = flush && warp_match(flush_warp, sched_warp);
    assign accept          = sched_valid && sched_ready;
    assign imem_req_addr   = req_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sched_ready    = 1'b0;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state)
            ST_IDLE: begin
                sched_ready = (count < (AW+1)'(FIFO_DEPTH));
                if (sched_valid && sched_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A flush landing on the response cycle itself must also discard it.
                if (imem_rsp_valid) begin
                    push      = !drop && !flush_hit_req;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_warp <= '0;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else if (accept) begin
            req_warp <= sched_warp;
            req_pc   <= sched_pc;
            drop     <= flush_hit_sched;
        end else if ((state != ST_IDLE) && flush_hit_req) begin
            drop <= 1'b1;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.warp  = req_warp;
        push_entry.pc    = req_pc;
        push_entry.instr = imem_rsp_data;
    end

    // Killed heads leave without a handshake so they never stall decode.
    assign dec_valid = !empty && !head_killed;
    assign pop       = !empty && (head_killed || dec_ready);
    assign dec_warp  = head.warp;
    assign dec_pc    = head.pc;
    assign dec_instr = head.instr;

    fetch_buffer #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .kill        (flush),
        .kill_warp   (flush_warp),
        .head        (head),
        .head_killed (head_killed),
        .count       (count),
        .empty       (empty)
    );

endmodule
